// File: rtl/logip_pkg.sv
// logip_pkg: shared states, constants and helpers for the logic-analyzer serial back-end
package logip_pkg;
  typedef enum logic [2:0] {IDLE, PAUSE, START, DATA, STOP} tx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int TX_MAX_BYTES = 4;
  function automatic logic [2:0] clamp_width(input logic [2:0] w);
    return (w > 3'(TX_MAX_BYTES)) ? 3'(TX_MAX_BYTES) : w;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one 8N1 frame per strobe, LSB first, done_o pulses on the last stop-bit cycle
module uart_tx_byte
  import logip_pkg::*;
#(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic       stb_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx_o
);
  localparam int CW = $clog2(CLK_PER_BIT);
  tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [9:0] sh_q, sh_d;
  logic tick;
  assign tick = cnt_q == CW'(CLK_PER_BIT - 1);
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == STOP && tick;
  assign tx_o = sh_q[0];
  // the shifter fills with ones, so the line rests high once the stop bit has gone out
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    if (stb_i) begin
      state_d = START;
      cnt_d = '0;
      bit_d = '0;
      sh_d = {1'b1, byte_i, 1'b0};
    end else if (busy_o && tick) begin
      cnt_d = '0;
      sh_d = {1'b1, sh_q[9:1]};
      bit_d = state_q == DATA ? bit_q + 3'd1 : '0;
      state_d = state_q == START ? DATA :
                (state_q == DATA && bit_q != 3'(UART_DATA_BITS - 1)) ? DATA :
                state_q == DATA ? STOP : IDLE;
    end else if (busy_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/transmitter.sv
// transmitter: sends a 1-4 byte word LSB first as back-to-back 8N1 frames with xon/xoff pausing
module transmitter
  import logip_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       width_i,
  input  logic             stb_i,
  input  logic             xon_i,
  input  logic             xoff_i,
  output logic             rdy_o,
  output logic             tx_o
);
  tx_state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0] width_q, width_d;
  logic [1:0] idx_q, idx_d;
  logic paused_q, paused_d;
  logic accept, last, done, busy, byte_stb;
  logic [7:0] byte_sel;
  assign rdy_o = state_q == IDLE;
  assign accept = rdy_o && stb_i && width_i != 3'd0;
  assign last = {1'b0, idx_q} + 3'd1 == width_q;
  // START here covers the whole frame in flight; the byte engine tracks the bit phases
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    width_d = width_q;
    idx_d = idx_q;
    paused_d = xoff_i ? 1'b1 : xon_i ? 1'b0 : paused_q;
    byte_stb = 1'b0;
    if (accept) begin
      data_d = data_i;
      width_d = clamp_width(width_i);
      idx_d = '0;
      state_d = paused_q ? PAUSE : START;
      byte_stb = !paused_q;
    end else if (state_q == PAUSE && !paused_q && !busy) begin
      state_d = START;
      byte_stb = 1'b1;
    end else if (state_q == START && done) begin
      idx_d = last ? idx_q : idx_q + 2'd1;
      state_d = last ? IDLE : paused_q ? PAUSE : START;
      byte_stb = !last && !paused_q;
    end
    byte_sel = accept ? data_i[7:0] : data_q[{idx_d, 3'b000} +: 8];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q <= IDLE;
      data_q <= '0;
      width_q <= '0;
      idx_q <= '0;
      paused_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      width_q <= width_d;
      idx_q <= idx_d;
      paused_q <= paused_d;
    end
  end
  uart_tx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_byte (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .stb_i (byte_stb),
    .byte_i(byte_sel),
    .busy_o(busy),
    .done_o(done),
    .tx_o  (tx_o)
  );
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: directed checks of framing, widths, flow control and reset at CLK_PER_BIT=4
module tb_transmitter;
  logic clk = 0, rst_n = 0, stb = 0, xon = 0, xoff = 0;
  logic [31:0] data = '0;
  logic [2:0] width = '0;
  logic rdy, tx;
  int checks = 0, errors = 0;

  transmitter #(.CLK_PER_BIT(4), .WIDTH(32)) dut (
    .clk_i(clk), .rst_in(rst_n), .data_i(data), .width_i(width),
    .stb_i(stb), .xon_i(xon), .xoff_i(xoff), .rdy_o(rdy), .tx_o(tx)
  );

  always #5 clk = ~clk;

  // called on the negedge right after the start edge; samples each bit mid-cell
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int n = 0;
    logic s, p;
    b = '0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    s = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx;
    end
    repeat (4) @(negedge clk);
    p = tx;
    ok = (n < 200) && s === 1'b0 && p === 1'b1;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (rdy !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL wait_rdy rdy=%b required 1", rdy);
    end
  endtask

  task automatic xfer(input logic [31:0] d, input logic [2:0] w, input int nb, input logic poke,
                      output logic [31:0] got, output logic okall, output int lowcyc,
                      output logic t0, output logic r0);
    logic [7:0] b;
    logic o;
    data = d;
    width = w;
    stb = 1;
    @(negedge clk);
    t0 = tx;
    r0 = rdy;
    fork
      begin
        stb = 0;
        lowcyc = 0;
        while (!rdy && lowcyc < 1000) begin
          lowcyc++;
          @(negedge clk);
        end
      end
      begin
        okall = 1;
        got = '0;
        for (int k = 0; k < nb; k++) begin
          rx_byte(b, o);
          got[8*k +: 8] = b;
          okall &= o;
        end
      end
      begin
        if (poke) begin
          repeat (30) @(negedge clk);
          data = 32'hFF;
          width = 3'd1;
          stb = 1;
          @(negedge clk);
          stb = 0;
        end
      end
    join
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state tx=%b rdy=%b required 1 1", tx, rdy);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL after_reset tx=%b rdy=%b required 1 1", tx, rdy);
    end
  endtask

  task automatic test_single();
    logic [31:0] got;
    logic ok, t0, r0;
    int lc;
    xfer(32'h000000A5, 3'd1, 1, 1'b0, got, ok, lc, t0, r0);
    checks++;
    if (t0 !== 1'b0 || r0 !== 1'b0) begin
      errors++;
      $display("FAIL single_latency tx=%b rdy=%b required 0 0", t0, r0);
    end
    checks++;
    if (got[7:0] !== 8'hA5 || !ok) begin
      errors++;
      $display("FAIL single_byte got=%h framing=%b required a5 1", got[7:0], ok);
    end
    checks++;
    if (lc != 40) begin
      errors++;
      $display("FAIL single_rdy_low cycles=%0d required 40", lc);
    end
  endtask

  task automatic test_four();
    logic [31:0] got;
    logic ok, t0, r0;
    int lc;
    xfer(32'h12345678, 3'd4, 4, 1'b1, got, ok, lc, t0, r0);
    checks++;
    if (got !== 32'h12345678 || !ok) begin
      errors++;
      $display("FAIL four_bytes got=%h framing=%b required 12345678 1", got, ok);
    end
    checks++;
    if (lc != 160) begin
      errors++;
      $display("FAIL four_rdy_low cycles=%0d required 160", lc);
    end
  endtask

  task automatic test_width();
    logic [31:0] got;
    logic ok, t0, r0;
    int lc, bad = 0;
    data = 32'h11;
    width = 3'd0;
    stb = 1;
    @(negedge clk);
    stb = 0;
    repeat (20) begin
      if (rdy !== 1'b1 || tx !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL width0_idle bad_cycles=%0d required 0", bad);
    end
    xfer(32'hDEADBEEF, 3'd7, 4, 1'b0, got, ok, lc, t0, r0);
    checks++;
    if (got !== 32'hDEADBEEF || !ok) begin
      errors++;
      $display("FAIL width7_bytes got=%h framing=%b required deadbeef 1", got, ok);
    end
    checks++;
    if (lc != 160) begin
      errors++;
      $display("FAIL width7_rdy_low cycles=%0d required 160", lc);
    end
  endtask

  task automatic test_flow();
    logic [7:0] b0, b1, b2;
    logic o0, o1, o2;
    int bad = 0;
    data = 32'h00C35A81;
    width = 3'd3;
    stb = 1;
    @(negedge clk);
    stb = 0;
    fork
      rx_byte(b0, o0);
      begin
        repeat (17) @(negedge clk);
        xoff = 1;
        @(negedge clk);
        xoff = 0;
      end
    join
    checks++;
    if (b0 !== 8'h81 || !o0) begin
      errors++;
      $display("FAIL flow_byte0 got=%h framing=%b required 81 1", b0, o0);
    end
    repeat (45) begin
      if (tx !== 1'b1 || rdy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flow_paused bad_cycles=%0d required 0", bad);
    end
    xon = 1;
    @(negedge clk);
    xon = 0;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL flow_xon_edge tx=%b required 1", tx);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL flow_resume_start tx=%b required 0", tx);
    end
    rx_byte(b1, o1);
    rx_byte(b2, o2);
    checks++;
    if (b1 !== 8'h5A || b2 !== 8'hC3 || !o1 || !o2) begin
      errors++;
      $display("FAIL flow_bytes12 got=%h %h framing=%b%b required 5a c3 11", b1, b2, o1, o2);
    end
    wait_rdy();
  endtask

  task automatic test_both();
    logic [7:0] b;
    logic o;
    int bad = 0;
    xon = 1;
    xoff = 1;
    @(negedge clk);
    xon = 0;
    xoff = 0;
    data = 32'h96;
    width = 3'd1;
    stb = 1;
    @(negedge clk);
    stb = 0;
    checks++;
    if (rdy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL both_pause_entry rdy=%b tx=%b required 0 1", rdy, tx);
    end
    repeat (20) begin
      if (tx !== 1'b1 || rdy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL both_held bad_cycles=%0d required 0", bad);
    end
    xon = 1;
    @(negedge clk);
    xon = 0;
    @(negedge clk);
    rx_byte(b, o);
    checks++;
    if (b !== 8'h96 || !o) begin
      errors++;
      $display("FAIL both_release got=%h framing=%b required 96 1", b, o);
    end
    wait_rdy();
  endtask

  task automatic test_rst_mid();
    logic [7:0] b;
    logic o, t0, r0;
    logic [31:0] got;
    int lc, bad = 0;
    data = 32'h000055AA;
    width = 3'd2;
    stb = 1;
    @(negedge clk);
    stb = 0;
    rx_byte(b, o);
    repeat (15) @(negedge clk);
    xoff = 1;
    rst_n = 0;
    @(negedge clk);
    xoff = 0;
    rst_n = 1;
    checks++;
    if (tx !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid tx=%b rdy=%b required 1 1", tx, rdy);
    end
    repeat (50) begin
      if (tx !== 1'b1 || rdy !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_discard bad_cycles=%0d required 0", bad);
    end
    xfer(32'h0000003C, 3'd1, 1, 1'b0, got, o, lc, t0, r0);
    checks++;
    if (t0 !== 1'b0 || got[7:0] !== 8'h3C || !o || lc != 40) begin
      errors++;
      $display("FAIL rst_fresh start=%b got=%h framing=%b low=%0d required 0 3c 1 40", t0, got[7:0], o, lc);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic o;
    int n = 0;
    data = 32'h0F;
    width = 3'd1;
    stb = 1;
    @(negedge clk);
    while (!rdy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    data = 32'hF0;
    @(negedge clk);
    stb = 0;
    checks++;
    if (n != 40 || tx !== 1'b0 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart low=%0d tx=%b rdy=%b required 40 0 0", n, tx, rdy);
    end
    rx_byte(b, o);
    checks++;
    if (b !== 8'hF0 || !o) begin
      errors++;
      $display("FAIL b2b_second got=%h framing=%b required f0 1", b, o);
    end
    wait_rdy();
  endtask

  initial begin
    test_reset();
    test_single();
    test_four();
    test_width();
    test_flow();
    test_both();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
